// File: rtl/amdc_spi_adc_multi.sv
// Multi-channel SPI ADC receiver: one shared CNV/SCLK pair and NUM_CH parallel MISO lines.
// Each conversion strobes CNV, clocks DATA_WIDTH bits MSB-first from every channel and latches them together.
module amdc_spi_adc_multi #(
    parameter int NUM_CH     = 2,
    parameter int DATA_WIDTH = 18
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [7:0]                   sclk_cnt,
    input  logic [7:0]                   cnv_cnt,
    input  logic                         sample_rise,
    input  logic                         clr_overrun,
    input  logic [NUM_CH-1:0]            miso,
    output logic                         sclk,
    output logic                         cnv,
    output logic [NUM_CH*DATA_WIDTH-1:0] data,
    output logic                         done,
    output logic                         valid,
    output logic                         busy,
    output logic                         overrun
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CNV   = 3'd1;
    localparam logic [2:0] S_RX    = 3'd2;
    localparam logic [2:0] S_LATCH = 3'd3;
    localparam logic [5:0] LAST_BIT = 6'(DATA_WIDTH - 1);

    logic [2:0]                             state;
    logic [7:0]                             cfg_sclk;
    logic [7:0]                             cnv_timer;
    logic [7:0]                             div_cnt;
    logic                                   cfg_rise;
    logic [5:0]                             bit_cnt;
    logic                                   sclk_q;
    logic [NUM_CH-1:0]                      miso_meta;
    logic [NUM_CH-1:0]                      miso_sync;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0]      shreg;
    logic                                   cap;

    // Edge detection compares sclk against its one-cycle-delayed copy, so
    // captures land one clk after the SCLK transition the ADCs see.
    assign cap = (state == S_RX) &&
                 (cfg_rise ? (sclk && !sclk_q) : (!sclk && sclk_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso_meta <= '0;
            miso_sync <= '0;
            sclk_q    <= 1'b0;
        end else begin
            miso_meta <= miso;
            miso_sync <= miso_meta;
            sclk_q    <= sclk;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cfg_sclk  <= '0;
            cfg_rise  <= 1'b0;
            cnv_timer <= '0;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            sclk      <= 1'b0;
            cnv       <= 1'b0;
            data      <= '0;
            done      <= 1'b0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            valid <= 1'b0;
            // A rejected start wins over a simultaneous clear.
            if (start && state != S_IDLE)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        cfg_sclk  <= sclk_cnt;
                        cfg_rise  <= sample_rise;
                        cnv_timer <= cnv_cnt;
                        bit_cnt   <= '0;
                        shreg     <= '0;
                        done      <= 1'b0;
                        cnv       <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_CNV;
                    end
                end
                S_CNV: begin
                    if (cnv_timer == 8'd0) begin
                        cnv     <= 1'b0;
                        sclk    <= 1'b0;
                        div_cnt <= cfg_sclk;
                        state   <= S_RX;
                    end else begin
                        cnv_timer <= cnv_timer - 8'd1;
                    end
                end
                S_RX: begin
                    if (div_cnt == 8'd0) begin
                        sclk    <= ~sclk;
                        div_cnt <= cfg_sclk;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                    if (cap) begin
                        for (int k = 0; k < NUM_CH; k++)
                            shreg[k] <= {shreg[k][DATA_WIDTH-2:0], miso_sync[k]};
                        bit_cnt <= bit_cnt + 6'd1;
                        // Last bit: park SCLK low now so no stray edge escapes.
                        if (bit_cnt == LAST_BIT) begin
                            sclk  <= 1'b0;
                            state <= S_LATCH;
                        end
                    end
                end
                S_LATCH: begin
                    data  <= shreg;
                    valid <= 1'b1;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state     <= S_IDLE;
                    cfg_sclk  <= '0;
                    cfg_rise  <= 1'b0;
                    cnv_timer <= '0;
                    div_cnt   <= '0;
                    bit_cnt   <= '0;
                    shreg     <= '0;
                    sclk      <= 1'b0;
                    cnv       <= 1'b0;
                    data      <= '0;
                    done      <= 1'b0;
                    valid     <= 1'b0;
                    busy      <= 1'b0;
                    overrun   <= 1'b0;
                end
            endcase
        end
    end

endmodule
